// File: rtl/rom_dl_router.sv
// Routes the data_io ROM byte stream into per-region SDRAM toggle-handshake write ports
// and sequences the core reset around ROM downloads.
module rom_dl_router #(
    parameter int                 NREG       = 2,
    parameter logic [25*NREG-1:0] REG_BASE   = {25'h08000, 25'h00000},
    parameter logic [24:0]        REG_END    = 25'h16320,
    parameter logic [7:0]         ROM_INDEX  = 8'h00,
    parameter int                 RESET_HOLD = 16
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            ioctl_download,
    input  logic [7:0]      ioctl_index,
    input  logic            ioctl_wr,
    input  logic [24:0]     ioctl_addr,
    input  logic [7:0]      ioctl_dout,
    input  logic            rst_req,
    output logic [NREG-1:0] port_req,
    input  logic [NREG-1:0] port_ack,
    output logic [22:0]     port_a,
    output logic [1:0]      port_ds,
    output logic [15:0]     port_d,
    output logic            rom_loaded,
    output logic            core_reset,
    output logic            overrun,
    output logic [7:0]      oor_cnt
);

    localparam logic [7:0] HOLD_INIT = 8'(RESET_HOLD);

    logic            wr_prev_r;
    logic            dl_prev_r;
    logic            rom_dl_r;
    logic [NREG-1:0] port_req_r;
    logic [22:0]     port_a_r;
    logic [1:0]      port_ds_r;
    logic [15:0]     port_d_r;
    logic            rom_loaded_r;
    logic            overrun_r;
    logic [7:0]      oor_cnt_r;
    logic [7:0]      hold_r;

    logic            idx_match_s;
    logic            strobe_s;
    logic            dl_rise_s;
    logic            dl_fall_s;
    logic            rom_start_s;
    logic            rom_end_s;
    logic            in_range_s;
    logic            busy_s;
    logic            cause_s;
    logic [NREG-1:0] ge_s;
    logic [NREG-1:0] sel_s;
    logic [24:0]     base_s;
    logic [7:0]      oor_base_s;
    logic [7:0]      oor_next_s;

    // Edge detection, region decode and reset-cause evaluation.
    always_comb begin
        idx_match_s = (ioctl_index == ROM_INDEX);
        strobe_s    = ioctl_wr & ~wr_prev_r & ioctl_download & idx_match_s;
        dl_rise_s   = ioctl_download & ~dl_prev_r;
        dl_fall_s   = ~ioctl_download & dl_prev_r;
        rom_start_s = dl_rise_s & idx_match_s;
        rom_end_s   = dl_fall_s & rom_dl_r;
        in_range_s  = (ioctl_addr >= REG_BASE[24:0]) && (ioctl_addr < REG_END);
        ge_s        = '0;
        base_s      = 25'h0000000;
        for (int i = 0; i < NREG; i++) begin
            ge_s[i] = (ioctl_addr >= REG_BASE[25*i +: 25]);
        end
        // Bases ascend, so ge_s is a thermometer code; its top set bit is the region.
        sel_s = ge_s & ~(ge_s >> 1);
        for (int i = 0; i < NREG; i++) begin
            base_s = base_s | (sel_s[i] ? REG_BASE[25*i +: 25] : 25'h0000000);
        end
        busy_s     = |(sel_s & (port_req_r ^ port_ack));
        oor_base_s = rom_start_s ? 8'h00 : oor_cnt_r;
        oor_next_s = (oor_base_s == 8'hFF) ? 8'hFF : (oor_base_s + 8'h01);
        cause_s    = rst_req | ~rom_loaded_r | (ioctl_download & idx_match_s);
    end

    // Write port: latch word address, strobes and data, then toggle the region request.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_prev_r  <= 1'b0;
            port_req_r <= '0;
            port_a_r   <= 23'h000000;
            port_ds_r  <= 2'b00;
            port_d_r   <= 16'h0000;
        end else begin
            wr_prev_r <= ioctl_wr;
            if (strobe_s && in_range_s) begin
                port_req_r <= port_req_r ^ sel_s;
                port_a_r   <= 23'((ioctl_addr - base_s) >> 1);
                port_ds_r  <= {ioctl_addr[0], ~ioctl_addr[0]};
                port_d_r   <= {ioctl_dout, ioctl_dout};
            end
        end
    end

    // Download tracking; the previous-download flag resets high so a download
    // already in flight across reset is never mistaken for a fresh start.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dl_prev_r <= 1'b1;
            rom_dl_r  <= 1'b0;
        end else begin
            dl_prev_r <= ioctl_download;
            if (dl_rise_s) begin
                rom_dl_r <= idx_match_s;
            end else if (dl_fall_s) begin
                rom_dl_r <= 1'b0;
            end
        end
    end

    // Status flags: reload clears, sticky overrun, saturating out-of-range count.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rom_loaded_r <= 1'b0;
            overrun_r    <= 1'b0;
            oor_cnt_r    <= 8'h00;
        end else begin
            if (rom_start_s) begin
                rom_loaded_r <= 1'b0;
                overrun_r    <= 1'b0;
                oor_cnt_r    <= 8'h00;
            end
            if (rom_end_s) begin
                rom_loaded_r <= 1'b1;
            end
            if (strobe_s && in_range_s && busy_s) begin
                overrun_r <= 1'b1;
            end
            if (strobe_s && !in_range_s) begin
                oor_cnt_r <= oor_next_s;
            end
        end
    end

    // Reset stretcher: reload on any cause, otherwise count down to zero.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            hold_r <= HOLD_INIT;
        end else if (cause_s) begin
            hold_r <= HOLD_INIT;
        end else if (hold_r != 8'h00) begin
            hold_r <= hold_r - 8'h01;
        end
    end

    assign port_req   = port_req_r;
    assign port_a     = port_a_r;
    assign port_ds    = port_ds_r;
    assign port_d     = port_d_r;
    assign rom_loaded = rom_loaded_r;
    assign overrun    = overrun_r;
    assign oor_cnt    = oor_cnt_r;
    // The live cause is ORed in so core_reset covers the cause cycle itself.
    assign core_reset = cause_s | (hold_r != 8'h00);

endmodule

// File: tb/tb_rom_dl_router.sv
// Randomized scoreboard bench for rom_dl_router against a region/handshake reference model.
module tb_rom_dl_router;

    logic        clk_sys;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        rst_req;
    logic [1:0]  port_req;
    logic [1:0]  port_ack;
    logic [22:0] port_a;
    logic [1:0]  port_ds;
    logic [15:0] port_d;
    logic        rom_loaded;
    logic        core_reset;
    logic        overrun;
    logic [7:0]  oor_cnt;

    rom_dl_router dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .rst_req        (rst_req),
        .port_req       (port_req),
        .port_ack       (port_ack),
        .port_a         (port_a),
        .port_ds        (port_ds),
        .port_d         (port_d),
        .rom_loaded     (rom_loaded),
        .core_reset     (core_reset),
        .overrun        (overrun),
        .oor_cnt        (oor_cnt)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int          r;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          base_a[2] = '{32'h0000000, 32'h0008000};
    int          reg_end = 32'h0016320;
    logic [1:0]  m_req;
    int          m_oor;
    logic        m_ovr;
    logic        m_loaded;
    logic        mon_en;
    logic        auto_ack;
    logic [1:0]  prev_req = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model of one qualified write strobe.
    task automatic model_strobe(input logic [24:0] addr, input logic [7:0] dout);
        exp_t e;
        int   r;
        if (ioctl_download !== 1'b1 || ioctl_index !== 8'h00) return;
        if (int'(addr) < base_a[0] || int'(addr) >= reg_end) begin
            m_oor = (m_oor >= 255) ? 255 : m_oor + 1;
        end else begin
            r = 0;
            for (int i = 0; i < 2; i++) if (int'(addr) >= base_a[i]) r = i;
            if (m_req[r] != port_ack[r]) m_ovr = 1'b1;
            m_req[r] = ~m_req[r];
            e.r  = r;
            e.a  = 23'((int'(addr) - base_a[r]) / 2);
            e.ds = addr[0] ? 2'b10 : 2'b01;
            e.d  = {dout, dout};
            sb.push_back(e);
        end
    endtask

    task automatic do_write(input logic [24:0] addr, input logic [7:0] dout);
        @(negedge clk_sys);
        ioctl_addr = addr;
        ioctl_dout = dout;
        ioctl_wr   = 1'b1;
        model_strobe(addr, dout);
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        if (auto_ack) port_ack = m_req;
        #1;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_req"}, port_req, m_req);
        chk({tag, "_oor"}, oor_cnt, m_oor);
        chk({tag, "_ovr"}, overrun, m_ovr);
        chk({tag, "_loaded"}, rom_loaded, m_loaded);
        chk({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    // Monitor: every port_req change must match the oldest expected write.
    always @(negedge clk_sys) begin
        exp_t e;
        if (mon_en === 1'b1 && port_req !== prev_req) begin
            if (sb.size() == 0) begin
                chk("unexpected_req", port_req, prev_req);
            end else begin
                e = sb.pop_front();
                chk("req_toggle", port_req ^ prev_req, 1 << e.r);
                chk("port_a", port_a, e.a);
                chk("port_ds", port_ds, e.ds);
                chk("port_d", port_d, e.d);
            end
        end
        prev_req = port_req;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [24:0] addr;
        logic [22:0] sv_a;
        logic [1:0]  sv_ds;
        logic [15:0] sv_d;
        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'h00; ioctl_wr = 1'b0;
        ioctl_addr = 25'h0; ioctl_dout = 8'h00; rst_req = 1'b0; port_ack = 2'b00;
        m_req = 2'b00; m_oor = 0; m_ovr = 1'b0; m_loaded = 1'b0; mon_en = 1'b0; auto_ack = 1'b1;
        repeat (3) @(negedge clk_sys);
        #1;
        chk("rst_port_req", port_req, 2'b00);
        chk("rst_port_a", port_a, 23'h0);
        chk("rst_port_ds", port_ds, 2'b00);
        chk("rst_port_d", port_d, 16'h0);
        chk("rst_rom_loaded", rom_loaded, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_oor_cnt", oor_cnt, 8'h00);
        chk("rst_core_reset", core_reset, 1'b1);
        @(negedge clk_sys);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        ioctl_index    = 8'h00;
        @(negedge clk_sys);

        do_write(25'h00003, 8'hA5);
        chk("w0_req", port_req, 2'b01);
        chk("w0_a", port_a, 23'd1);
        chk("w0_ds", port_ds, 2'b10);
        chk("w0_d", port_d, 16'hA5A5);
        do_write(25'h08004, 8'h3C);
        chk("w1_req", port_req, 2'b11);
        chk("w1_a", port_a, 23'd2);
        chk("w1_ds", port_ds, 2'b01);
        chk("w1_d", port_d, 16'h3C3C);

        do_write(25'h16320, 8'h11);
        chk("oor_first_req", port_req, 2'b11);
        chk("oor_first_cnt", oor_cnt, 8'h01);
        repeat (300) do_write(25'($urandom_range(32'h1FFFFFF, 32'h0016320)), 8'($urandom));
        chk("oor_sat", oor_cnt, 8'hFF);
        chk_status("oor");

        do_write(25'h07FFF, 8'h5A);
        do_write(25'h08000, 8'hC3);
        do_write(25'h1631F, 8'h96);
        chk_status("edges");
        repeat (60) begin
            addr = 25'($urandom_range(32'h0016400, 32'h0));
            do_write(addr, 8'($urandom));
        end
        chk_status("rand");

        auto_ack = 1'b0;
        do_write(25'h00010, 8'h01);
        chk("ovr_first", overrun, 1'b0);
        do_write(25'h00011, 8'h02);
        chk("ovr_second", overrun, 1'b1);
        chk_status("ovr");

        @(negedge clk_sys);
        ioctl_download = 1'b0;
        m_loaded = 1'b1;
        @(negedge clk_sys);
        #1;
        chk("loaded_next", rom_loaded, 1'b1);
        chk("loaded_core_reset_hi", core_reset, 1'b1);
        n = 0;
        while (core_reset === 1'b1 && n < 100) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        chk("core_reset_fall_cycles", n, 16);

        sv_a = port_a; sv_ds = port_ds; sv_d = port_d;
        @(negedge clk_sys);
        ioctl_index    = 8'h01;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        do_write(25'h00020, 8'h77);
        chk("idx1_req", port_req, m_req);
        chk("idx1_a", port_a, sv_a);
        chk("idx1_ds", port_ds, sv_ds);
        chk("idx1_d", port_d, sv_d);
        chk("idx1_core_reset", core_reset, 1'b0);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        ioctl_index = 8'h00;
        #1;
        chk_status("idx1");
        chk("idx1_end_core_reset", core_reset, 1'b0);

        @(negedge clk_sys);
        rst_req = 1'b1;
        #1;
        n = 0;
        while (core_reset === 1'b1 && n < 100) begin
            n++;
            @(negedge clk_sys);
            rst_req = 1'b0;
            #1;
        end
        chk("rst_req_pulse_cycles", n, 17);

        @(negedge clk_sys);
        ioctl_download = 1'b1;
        m_ovr = 1'b0; m_oor = 0; m_loaded = 1'b0;
        port_ack = m_req;
        auto_ack = 1'b1;
        @(negedge clk_sys);
        #1;
        chk("reload_overrun", overrun, 1'b0);
        chk("reload_oor", oor_cnt, 8'h00);
        chk("reload_loaded", rom_loaded, 1'b0);
        chk("reload_core_reset", core_reset, 1'b1);
        do_write(25'h0000A, 8'hE1);
        do_write(25'h08001, 8'h1E);
        chk_status("reload");

        @(negedge clk_sys);
        mon_en = 1'b0;
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        m_req = 2'b00; m_oor = 0; m_ovr = 1'b0; m_loaded = 1'b0;
        port_ack = 2'b00;
        #1;
        mon_en = 1'b1;
        chk("midrst_req", port_req, 2'b00);
        chk("midrst_a", port_a, 23'h0);
        chk("midrst_core_reset", core_reset, 1'b1);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (30) begin
            @(negedge clk_sys);
            #1;
            chk("midrst_loaded", rom_loaded, 1'b0);
            chk("midrst_core_reset_hold", core_reset, 1'b1);
        end
        chk_status("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_dl_router.md
ROM_DL_ROUTER -- requirements
Module: rom_dl_router

Interface
REQ-001 SHALL have parameter NREG, default 2: number of SDRAM regions/ports, legal range 1..8.
REQ-002 SHALL have parameter REG_BASE, default {25'h08000, 25'h00000}: NREG packed 25-bit byte base addresses, region i in bits [25*i+:25], strictly ascending with i.
REQ-003 SHALL have parameter REG_END, default 25'h16320: exclusive byte end of the last region.
REQ-004 SHALL have parameter ROM_INDEX, default 8'h00: ioctl_index value that identifies a ROM download.
REQ-005 SHALL have parameter RESET_HOLD, default 16: minimum core_reset cycles after all reset causes clear, legal range 1..255.
REQ-006 SHALL have port clk_sys, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have ports ioctl_download (input, 1), ioctl_index (input, 8), ioctl_wr (input, 1), ioctl_addr (input, 25), ioctl_dout (input, 8): data_io byte stream.
REQ-009 SHALL have port rst_req, input, 1 bit: external reset cause (OSD reset or button).
REQ-010 SHALL have port port_req, output, NREG bits: per-region toggle request.
REQ-011 SHALL have port port_ack, input, NREG bits: per-region toggle acknowledge from SDRAM.
REQ-012 SHALL have ports port_a (output, 23), port_ds (output, 2), port_d (output, 16): shared write word address (region-relative), byte strobes {hi,lo}, data.
REQ-013 SHALL have ports rom_loaded (output, 1), core_reset (output, 1), overrun (output, 1), oor_cnt (output, 8).

Function
REQ-014 SHALL detect a write strobe as ioctl_wr=1 at an edge where the registered previous ioctl_wr=0, qualified by ioctl_download=1 and ioctl_index==ROM_INDEX.
REQ-015 SHALL select region r as the highest i with ioctl_addr >= base[i], provided ioctl_addr < base[i+1] (or < REG_END for the last region).
REQ-016 SHALL, on the strobe edge for an in-range address, register port_a=(ioctl_addr-base[r])>>1, port_ds={addr[0],~addr[0]}, port_d={dout,dout}, and toggle port_req[r]; outputs are valid the cycle after the edge, with latency 1.
REQ-017 SHALL leave port_a/ds/d and port_req unchanged for non-strobe cycles and non-matching index.
REQ-018 SHALL, for an address below base[0] or at/above REG_END, drop the write and increment oor_cnt, saturating at 8'hFF.
REQ-019 SHALL set overrun (sticky) when a strobe targets region r while port_req[r]!=port_ack[r]; that write SHALL still be issued by toggling the request.
REQ-020 SHALL treat the rising edge of ioctl_download with index ROM_INDEX as a reload: clear rom_loaded, overrun and oor_cnt on that edge.
REQ-021 SHALL set rom_loaded on the falling edge of ioctl_download when the index latched at start equals ROM_INDEX; other indices SHALL NOT affect rom_loaded.
REQ-022 SHALL hold an 8-bit hold counter, reloaded to RESET_HOLD on any cycle with rst_req=1, rom_loaded=0, or a ROM_INDEX download active, and decremented to 0 otherwise.
REQ-023 SHALL drive core_reset=1 whenever the hold counter is nonzero, so it deasserts exactly RESET_HOLD cycles after the last cause cycle.
REQ-024 SHALL apply simultaneous strobe and download-falling edges in the order strobe first, then rom_loaded set.

Reset
REQ-025 SHALL, at an edge with reset_n=0: port_req=0, previous wr=0, port_a/ds/d=0, rom_loaded=0, overrun=0, oor_cnt=0, hold counter=RESET_HOLD, core_reset=1.
REQ-026 SHALL, for reset mid-download, discard the download; rom_loaded SHALL stay 0 until a later complete download.
REQ-027 SHALL NOT require port_ack to be reset; the first strobe after reset compares against the live port_ack.

Verification
REQ-028 SHALL test: defaults; write addr 25'h00003, dout 8'hA5 -> next cycle port_req[0] toggles, port_a=1, port_ds=2'b10, port_d=16'hA5A5.
REQ-029 SHALL test: write addr 25'h08004 -> port_req[1] toggles, port_a=2, port_ds=2'b01; port_req[0] is unchanged.
REQ-030 SHALL test: write addr 25'h16320 -> no port_req change, oor_cnt=1; then 300 more out-of-range writes -> oor_cnt=8'hFF.
REQ-031 SHALL test: two strobes to region 0 with port_ack held -> overrun=1 after the second; next ROM download start -> overrun=0.
REQ-032 SHALL test: download falls, rst_req=0 -> rom_loaded=1 next cycle, core_reset falls exactly 16 cycles later; a 1-cycle rst_req pulse -> core_reset high for 17 cycles.
REQ-033 SHALL test: reset_n low for 1 cycle mid-download, then the download ends -> rom_loaded stays 0 and core_reset stays 1.
